// File: rtl/timesync_master_pkg.sv
// Shared definitions for the board-to-board timesync master: default command codes,
// FSM state encoding and the toggle-period clamp.
package timesync_master_pkg;

    localparam logic [7:0]  CMD_TS_CONFIG_DEF = 8'd0;
    localparam logic [7:0]  CMD_TS_LATCH_DEF  = 8'd0;
    localparam logic [31:0] RSP_TS_LATCH_DEF  = 32'd0;
    localparam logic [63:0] NO_TIME           = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG_END = 3'd1,
        ST_WAIT    = 3'd2,
        ST_GUARD   = 3'd3,
        ST_RSP_LO  = 3'd4,
        ST_RSP_HI  = 3'd5,
        ST_RSP_END = 3'd6
    } ts_state_e;

    function automatic logic [31:0] clamp_period(input logic [31:0] v, input logic [31:0] min_p);
        logic [31:0] r;
        if (v == 32'd0) begin
            r = 32'd0;
        end else if (v < min_p) begin
            r = min_p;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/timesync_period_gen.sv
// Toggle generator: period register, down-counter, toggle line and the time captured
// at each toggle edge.
module timesync_period_gen
    import timesync_master_pkg::*;
#(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd0,
    parameter logic [31:0] MIN_PERIOD     = 32'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic [63:0] time_in,
    output logic        pulse_out,
    output logic [63:0] pulse_time,
    output logic        toggle,
    output logic        period_zero
);

    localparam logic [31:0] RST_PERIOD = clamp_period(DEFAULT_PERIOD, MIN_PERIOD);
    localparam logic [31:0] RST_COUNT  = (RST_PERIOD == 32'd0) ? 32'd0 : RST_PERIOD - 32'd1;

    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] new_period_s;
    logic        pulse_q, pulse_d;
    logic [63:0] pulse_time_q, pulse_time_d;

    // A load restarts the count, so it also suppresses a toggle due on the same edge.
    always_comb begin
        new_period_s = clamp_period(load_value, MIN_PERIOD);
        toggle       = (period_q != 32'd0) && (cnt_q == 32'd0) && !load;
        period_d     = period_q;
        cnt_d        = cnt_q;
        pulse_d      = pulse_q;
        pulse_time_d = pulse_time_q;
        if (load) begin
            period_d = new_period_s;
            cnt_d    = (new_period_s == 32'd0) ? 32'd0 : new_period_s - 32'd1;
        end else if (toggle) begin
            cnt_d        = period_q - 32'd1;
            pulse_d      = !pulse_q;
            pulse_time_d = time_in;
        end else if (period_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_q     <= RST_PERIOD;
            cnt_q        <= RST_COUNT;
            pulse_q      <= 1'b0;
            pulse_time_q <= 64'd0;
        end else begin
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
            pulse_time_q <= pulse_time_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign pulse_time  = pulse_time_q;
    assign period_zero = (period_q == 32'd0);

endmodule

// File: rtl/timesync_master.sv
// Timesync master: drives the toggle and latch lines to slave boards and answers the
// host's latch request with the master time of the toggle that preceded the latch.
module timesync_master
    import timesync_master_pkg::*;
#(
    parameter int unsigned          CMD_BITS       = 8,
    parameter logic [CMD_BITS-1:0]  CMD_TS_CONFIG  = CMD_BITS'(CMD_TS_CONFIG_DEF),
    parameter logic [CMD_BITS-1:0]  CMD_TS_LATCH   = CMD_BITS'(CMD_TS_LATCH_DEF),
    parameter logic [31:0]          RSP_TS_LATCH   = RSP_TS_LATCH_DEF,
    parameter logic [31:0]          DEFAULT_PERIOD = 32'd0,
    parameter logic [31:0]          MIN_PERIOD     = 32'd64,
    parameter int unsigned          GUARD          = 8,
    parameter int unsigned          LATCH_HOLD     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         arg_data,
    output logic                arg_advance,
    input  logic [CMD_BITS-1:0] cmd,
    input  logic                cmd_ready,
    output logic                cmd_done,
    output logic [31:0]         param_data,
    output logic                param_write,
    input  logic [63:0]         time_in,
    output logic                timesync_pulse_out,
    output logic                timesync_latch_out
);

    if ((MIN_PERIOD < 32'(2 * GUARD + 4)) || (GUARD < 1) || (LATCH_HOLD < 1)) begin : g_bad_params
        $error("timesync_master: MIN_PERIOD must be >= 2*GUARD+4, GUARD and LATCH_HOLD >= 1");
    end

    // Guard counts to zero, so loading GUARD-1 puts the latch rise exactly GUARD edges after the toggle.
    localparam logic [15:0] GUARD_LOAD = 16'(GUARD - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(LATCH_HOLD);

    ts_state_e   state_q, state_d;
    logic [15:0] guard_q, guard_d;
    logic [15:0] hold_q, hold_d;
    logic        latch_q, latch_d;
    logic [63:0] snap_q, snap_d;
    logic        arg_advance_q, arg_advance_d;
    logic        cmd_done_q, cmd_done_d;
    logic        param_write_q, param_write_d;
    logic [31:0] param_data_q, param_data_d;
    logic        load_s;
    logic        toggle_s;
    logic        period_zero_s;
    logic [63:0] pulse_time_s;

    timesync_period_gen #(
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .MIN_PERIOD     (MIN_PERIOD)
    ) u_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_s),
        .load_value  (arg_data),
        .time_in     (time_in),
        .pulse_out   (timesync_pulse_out),
        .pulse_time  (pulse_time_s),
        .toggle      (toggle_s),
        .period_zero (period_zero_s)
    );

    // Host-visible outputs are registered, so they trail the state that produced them by one edge.
    always_comb begin
        state_d       = state_q;
        guard_d       = guard_q;
        hold_d        = hold_q;
        latch_d       = latch_q;
        snap_d        = snap_q;
        load_s        = 1'b0;
        arg_advance_d = 1'b0;
        cmd_done_d    = 1'b0;
        param_write_d = 1'b0;
        param_data_d  = 32'd0;

        if (hold_q != 16'd0) begin
            hold_d = hold_q - 16'd1;
            if (hold_q == 16'd1) begin
                latch_d = 1'b0;
            end else begin
                latch_d = latch_q;
            end
        end else begin
            hold_d = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_ready && (cmd == CMD_TS_CONFIG)) begin
                    load_s        = 1'b1;
                    arg_advance_d = 1'b1;
                    state_d       = ST_CFG_END;
                end else if (cmd_ready && (cmd == CMD_TS_LATCH)) begin
                    if (period_zero_s) begin
                        snap_d  = NO_TIME;
                        state_d = ST_RSP_LO;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CFG_END: begin
                cmd_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_WAIT: begin
                if ((hold_q == 16'd0) && toggle_s) begin
                    guard_d = GUARD_LOAD;
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GUARD: begin
                // The generator's capture still holds the toggle time; no toggle can intervene.
                if (guard_q == 16'd0) begin
                    latch_d = 1'b1;
                    hold_d  = HOLD_LOAD;
                    snap_d  = pulse_time_s;
                    state_d = ST_RSP_LO;
                end else begin
                    guard_d = guard_q - 16'd1;
                end
            end
            ST_RSP_LO: begin
                param_write_d = 1'b1;
                param_data_d  = snap_q[31:0];
                state_d       = ST_RSP_HI;
            end
            ST_RSP_HI: begin
                param_write_d = 1'b1;
                param_data_d  = snap_q[63:32];
                state_d       = ST_RSP_END;
            end
            ST_RSP_END: begin
                param_data_d = RSP_TS_LATCH;
                cmd_done_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            guard_q       <= 16'd0;
            hold_q        <= 16'd0;
            latch_q       <= 1'b0;
            snap_q        <= 64'd0;
            arg_advance_q <= 1'b0;
            cmd_done_q    <= 1'b0;
            param_write_q <= 1'b0;
            param_data_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            guard_q       <= guard_d;
            hold_q        <= hold_d;
            latch_q       <= latch_d;
            snap_q        <= snap_d;
            arg_advance_q <= arg_advance_d;
            cmd_done_q    <= cmd_done_d;
            param_write_q <= param_write_d;
            param_data_q  <= param_data_d;
        end
    end

    assign arg_advance        = arg_advance_q;
    assign cmd_done           = cmd_done_q;
    assign param_write        = param_write_q;
    assign param_data         = param_data_q;
    assign timesync_latch_out = latch_q;

endmodule
